// File: rtl/vx_issue_scoreboard.sv
// Per-warp register scoreboard: blocks issue on RAW/WAW hazards against in-flight
// destinations, tracks stall cycles, and flags deadlock and spurious writebacks.
module vx_issue_scoreboard #(
    parameter int NUM_WARPS       = 4,
    parameter int NUM_REGS        = 64,
    parameter int DEADLOCK_CYCLES = 100000,
    localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int REG_W = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ibuf_valid,
    output logic             ibuf_ready,
    input  logic [WID_W-1:0] ibuf_wid,
    input  logic             ibuf_wb,
    input  logic [REG_W-1:0] ibuf_rd,
    input  logic [REG_W-1:0] ibuf_rs1,
    input  logic [REG_W-1:0] ibuf_rs2,
    input  logic [REG_W-1:0] ibuf_rs3,
    input  logic [2:0]       ibuf_use_rs,
    output logic             issue_valid,
    input  logic             issue_ready,
    input  logic             wb_valid,
    input  logic [WID_W-1:0] wb_wid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_eop,
    output logic [63:0]      perf_stalls,
    output logic             deadlock,
    output logic             wb_error
);

    localparam int CNT_W = $clog2(DEADLOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEADLOCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(DEADLOCK_CYCLES - 1);

    logic [NUM_WARPS-1:0][NUM_REGS-1:0] inuse_q, inuse_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [63:0]      perf_stalls_q, perf_stalls_d;
    logic             deadlock_q, deadlock_d;
    logic             wb_error_q, wb_error_d;

    logic [NUM_REGS-1:0] warp_busy_s;
    logic                hazard_s;
    logic                fire_s;
    logic                stall_s;
    logic                clear_s;

    // Hazard detection against registered busy bits only; no writeback bypass.
    always_comb begin
        warp_busy_s = inuse_q[ibuf_wid];
        hazard_s    = (ibuf_use_rs[0] & warp_busy_s[ibuf_rs1])
                    | (ibuf_use_rs[1] & warp_busy_s[ibuf_rs2])
                    | (ibuf_use_rs[2] & warp_busy_s[ibuf_rs3])
                    | (ibuf_wb        & warp_busy_s[ibuf_rd]);
        issue_valid = ibuf_valid & ~hazard_s;
        ibuf_ready  = issue_ready & ~hazard_s;
        fire_s      = ibuf_valid & ibuf_ready;
        stall_s     = ibuf_valid & hazard_s;
        clear_s     = wb_valid & wb_eop;
    end

    // Next-state: busy bits (set after clear so set wins), counters and sticky flags.
    always_comb begin
        inuse_d = inuse_q;
        if (clear_s) begin
            inuse_d[wb_wid][wb_rd] = 1'b0;
        end else begin
            inuse_d = inuse_q;
        end
        if (fire_s && ibuf_wb && (ibuf_rd != '0)) begin
            inuse_d[ibuf_wid][ibuf_rd] = 1'b1;
        end else begin
            inuse_d = inuse_d;
        end
        // Register 0 is hardwired; it can never become busy.
        for (int w = 0; w < NUM_WARPS; w++) begin
            inuse_d[w][0] = 1'b0;
        end

        if (clear_s && (wb_rd != '0) && !inuse_q[wb_wid][wb_rd]) begin
            wb_error_d = 1'b1;
        end else begin
            wb_error_d = wb_error_q;
        end

        if (stall_s) begin
            perf_stalls_d = perf_stalls_q + 64'd1;
            stall_cnt_d   = (stall_cnt_q < CNT_MAX) ? (stall_cnt_q + CNT_W'(1)) : stall_cnt_q;
            deadlock_d    = deadlock_q | (stall_cnt_q >= CNT_TRIP);
        end else begin
            perf_stalls_d = perf_stalls_q;
            stall_cnt_d   = '0;
            deadlock_d    = deadlock_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            inuse_q       <= '0;
            stall_cnt_q   <= '0;
            perf_stalls_q <= 64'd0;
            deadlock_q    <= 1'b0;
            wb_error_q    <= 1'b0;
        end else begin
            inuse_q       <= inuse_d;
            stall_cnt_q   <= stall_cnt_d;
            perf_stalls_q <= perf_stalls_d;
            deadlock_q    <= deadlock_d;
            wb_error_q    <= wb_error_d;
        end
    end

    assign perf_stalls = perf_stalls_q;
    assign deadlock    = deadlock_q;
    assign wb_error    = wb_error_q;

endmodule

// File: tb/tb_vx_issue_scoreboard.sv
// Directed bench for vx_issue_scoreboard: expectations queued at drive time,
// popped and compared when the DUT response is sampled.
module tb_vx_issue_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        ibuf_valid;
    logic        ibuf_ready;
    logic [1:0]  ibuf_wid;
    logic        ibuf_wb;
    logic [5:0]  ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3;
    logic [2:0]  ibuf_use_rs;
    logic        issue_valid;
    logic        issue_ready;
    logic        wb_valid;
    logic [1:0]  wb_wid;
    logic [5:0]  wb_rd;
    logic        wb_eop;
    logic [63:0] perf_stalls;
    logic        deadlock;
    logic        wb_error;

    vx_issue_scoreboard #(
        .NUM_WARPS(4), .NUM_REGS(64), .DEADLOCK_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset),
        .ibuf_valid(ibuf_valid), .ibuf_ready(ibuf_ready), .ibuf_wid(ibuf_wid),
        .ibuf_wb(ibuf_wb), .ibuf_rd(ibuf_rd), .ibuf_rs1(ibuf_rs1),
        .ibuf_rs2(ibuf_rs2), .ibuf_rs3(ibuf_rs3), .ibuf_use_rs(ibuf_use_rs),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd), .wb_eop(wb_eop),
        .perf_stalls(perf_stalls), .deadlock(deadlock), .wb_error(wb_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic exp_push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic obs_pop(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL underflow: observed %0h with no expectation queued", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ib(input logic v, input logic [1:0] wid, input logic wb,
                      input logic [5:0] rd, input logic [5:0] rs1, input logic [2:0] use_rs);
        ibuf_valid  = v;
        ibuf_wid    = wid;
        ibuf_wb     = wb;
        ibuf_rd     = rd;
        ibuf_rs1    = rs1;
        ibuf_rs2    = 6'd0;
        ibuf_rs3    = 6'd0;
        ibuf_use_rs = use_rs;
    endtask

    task automatic wbk(input logic v, input logic [1:0] wid, input logic [5:0] rd, input logic eop);
        wb_valid = v;
        wb_wid   = wid;
        wb_rd    = rd;
        wb_eop   = eop;
    endtask

    task automatic chk_iv(input string tag, input logic iv);
        exp_push(tag, {63'd0, iv});
        #1;
        obs_pop({63'd0, issue_valid});
    endtask

    // Directed sequence.
    initial begin
        reset = 1'b1;
        issue_ready = 1'b1;
        ib(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 3'b000);
        wbk(1'b0, 2'd0, 6'd0, 1'b0);
        tick(2);
        reset = 1'b0;
        tick(1);

        // Reset state
        exp_push("rst_perf", 64'd0);      obs_pop(perf_stalls);
        exp_push("rst_deadlock", 64'd0);  obs_pop({63'd0, deadlock});
        exp_push("rst_wb_error", 64'd0);  obs_pop({63'd0, wb_error});
        chk_iv("rst_iv_idle", 1'b0);
        exp_push("rst_ready", 64'd1);     obs_pop({63'd0, ibuf_ready});

        // RAW: issue rd5, dependent stalls until clear
        ib(1'b1, 2'd0, 1'b1, 6'd5, 6'd0, 3'b000);
        chk_iv("raw_first_iv", 1'b1);
        tick(1);
        ib(1'b1, 2'd0, 1'b0, 6'd0, 6'd5, 3'b001);
        chk_iv("raw_dep_iv", 1'b0);
        exp_push("raw_dep_ready", 64'd0); obs_pop({63'd0, ibuf_ready});
        tick(3);
        exp_push("raw_perf3", 64'd3);     obs_pop(perf_stalls);
        wbk(1'b1, 2'd0, 6'd5, 1'b1);
        chk_iv("raw_no_bypass", 1'b0);
        tick(1);
        wbk(1'b0, 2'd0, 6'd0, 1'b0);
        chk_iv("raw_after_clear", 1'b1);
        exp_push("raw_perf4", 64'd4);     obs_pop(perf_stalls);
        tick(1);

        // Per-warp isolation
        ib(1'b1, 2'd0, 1'b1, 6'd7, 6'd0, 3'b000);
        tick(1);
        ib(1'b1, 2'd1, 1'b0, 6'd0, 6'd7, 3'b001);
        chk_iv("warp1_no_hazard", 1'b1);
        ib(1'b1, 2'd0, 1'b0, 6'd0, 6'd7, 3'b001);
        chk_iv("warp0_rd7_busy", 1'b0);
        ib(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 3'b000);
        wbk(1'b1, 2'd0, 6'd7, 1'b1);
        tick(1);
        wbk(1'b0, 2'd0, 6'd0, 1'b0);

        // WAW on rd9, then simultaneous set rd10 / clear rd9
        ib(1'b1, 2'd0, 1'b1, 6'd9, 6'd0, 3'b000);
        tick(1);
        chk_iv("waw_stall", 1'b0);
        tick(1);
        wbk(1'b1, 2'd0, 6'd9, 1'b1);
        tick(1);
        wbk(1'b0, 2'd0, 6'd0, 1'b0);
        chk_iv("waw_released", 1'b1);
        exp_push("waw_perf6", 64'd6);     obs_pop(perf_stalls);
        tick(1);
        ib(1'b1, 2'd0, 1'b1, 6'd10, 6'd0, 3'b000);
        wbk(1'b1, 2'd0, 6'd9, 1'b1);
        chk_iv("set_clr_issue", 1'b1);
        tick(1);
        wbk(1'b0, 2'd0, 6'd0, 1'b0);
        ib(1'b1, 2'd0, 1'b0, 6'd0, 6'd9, 3'b001);
        chk_iv("set_clr_rd9_free", 1'b1);
        ib(1'b1, 2'd0, 1'b0, 6'd0, 6'd10, 3'b001);
        chk_iv("set_clr_rd10_busy", 1'b0);
        ib(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 3'b000);
        wbk(1'b1, 2'd0, 6'd10, 1'b1);
        tick(1);
        wbk(1'b0, 2'd0, 6'd0, 1'b0);
        exp_push("waw_wb_error", 64'd0);  obs_pop({63'd0, wb_error});

        // Register 0 never busy
        ib(1'b1, 2'd2, 1'b1, 6'd0, 6'd0, 3'b000);
        tick(1);
        ib(1'b1, 2'd2, 1'b1, 6'd0, 6'd0, 3'b001);
        chk_iv("r0_no_stall", 1'b1);
        tick(1);
        ib(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 3'b000);
        wbk(1'b1, 2'd2, 6'd0, 1'b1);
        tick(1);
        wbk(1'b0, 2'd0, 6'd0, 1'b0);
        exp_push("r0_wb_error", 64'd0);   obs_pop({63'd0, wb_error});
        exp_push("r0_perf", 64'd6);       obs_pop(perf_stalls);

        // Spurious clear, then multi-packet writeback
        wbk(1'b1, 2'd3, 6'd12, 1'b1);
        tick(1);
        wbk(1'b0, 2'd0, 6'd0, 1'b0);
        exp_push("spur_wb_error", 64'd1); obs_pop({63'd0, wb_error});
        ib(1'b1, 2'd3, 1'b1, 6'd12, 6'd0, 3'b000);
        tick(1);
        ib(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 3'b000);
        wbk(1'b1, 2'd3, 6'd12, 1'b0);
        tick(1);
        wbk(1'b0, 2'd0, 6'd0, 1'b0);
        ib(1'b1, 2'd3, 1'b0, 6'd0, 6'd12, 3'b001);
        chk_iv("mp_still_busy", 1'b0);
        ib(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 3'b000);
        wbk(1'b1, 2'd3, 6'd12, 1'b1);
        tick(1);
        wbk(1'b0, 2'd0, 6'd0, 1'b0);
        ib(1'b1, 2'd3, 1'b0, 6'd0, 6'd12, 3'b001);
        chk_iv("mp_cleared", 1'b1);
        exp_push("spur_sticky", 64'd1);   obs_pop({63'd0, wb_error});
        ib(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 3'b000);

        // Deadlock after 8 consecutive hazard cycles
        ib(1'b1, 2'd1, 1'b1, 6'd20, 6'd0, 3'b000);
        tick(1);
        ib(1'b1, 2'd1, 1'b0, 6'd0, 6'd20, 3'b001);
        tick(7);
        exp_push("dl_at7", 64'd0);        obs_pop({63'd0, deadlock});
        tick(1);
        exp_push("dl_at8", 64'd1);        obs_pop({63'd0, deadlock});
        exp_push("dl_perf14", 64'd14);    obs_pop(perf_stalls);
        ib(1'b1, 2'd1, 1'b1, 6'd21, 6'd0, 3'b000);
        tick(1);
        ib(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 3'b000);
        tick(2);
        exp_push("dl_sticky", 64'd1);     obs_pop({63'd0, deadlock});

        // Reset mid-operation drops busy bits
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        ib(1'b1, 2'd1, 1'b0, 6'd0, 6'd21, 3'b001);
        chk_iv("rst_drops_busy", 1'b1);
        exp_push("rst2_deadlock", 64'd0); obs_pop({63'd0, deadlock});

        // Back-pressure only: no stall counting, no deadlock
        issue_ready = 1'b0;
        tick(20);
        chk_iv("bp_iv", 1'b1);
        exp_push("bp_ready", 64'd0);      obs_pop({63'd0, ibuf_ready});
        exp_push("bp_deadlock", 64'd0);   obs_pop({63'd0, deadlock});
        exp_push("bp_perf", 64'd0);       obs_pop(perf_stalls);
        issue_ready = 1'b1;
        ib(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 3'b000);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain: observed %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vx_issue_scoreboard.md
# VX_issue_scoreboard

Per-warp register scoreboard between the instruction buffer and the instruction demux. It holds back any instruction whose source or destination registers are still pending writeback from an earlier in-flight instruction. It marks the destination register busy when an instruction issues and clears it when the commit stage retires that register's last writeback packet. It also provides a stall performance counter and a sticky deadlock and protocol-error flag for debug.

## Interface
Parameters:
- NUM_WARPS, 4, warps tracked; WID width = log2(NUM_WARPS) (min 1)
- NUM_REGS, 64, architectural registers per warp (32 integer + 32 FP); REG width = log2(NUM_REGS)
- DEADLOCK_CYCLES, 100000, consecutive hazard-stall cycles before the deadlock flag asserts

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ibuf_valid  in  1  instruction buffer presents an instruction
- ibuf_ready  out  1  scoreboard and downstream accept it
- ibuf_wid  in  WID  warp id
- ibuf_wb  in  1  instruction writes rd
- ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3  in  REG each  register indices
- ibuf_use_rs  in  3  per-source use enables {rs3, rs2, rs1}
- issue_valid  out  1  instruction forwarded to demux
- issue_ready  in  1  demux can accept
- wb_valid  in  1  commit writeback packet valid
- wb_wid  in  WID  writeback warp
- wb_rd  in  REG  writeback register
- wb_eop  in  1  last packet of this writeback
- perf_stalls  out  64  cycles with ibuf_valid=1 and hazard=1
- deadlock  out  1  sticky; hazard stall persisted DEADLOCK_CYCLES cycles
- wb_error  out  1  sticky; clear requested on a non-busy register

## Operation
- State: inuse[NUM_WARPS][NUM_REGS] flops; stall_cnt (width to hold DEADLOCK_CYCLES); perf_stalls; deadlock; wb_error.
- hazard (combinational, from registered inuse only; no same-cycle writeback bypass):
  - (use_rs[0] & inuse[wid][rs1]) | (use_rs[1] & inuse[wid][rs2]) | (use_rs[2] & inuse[wid][rs3]) | (ibuf_wb & inuse[wid][rd]).
  - Index 0 never hazards and is never marked busy.
- issue_valid = ibuf_valid & ~hazard; ibuf_ready = issue_ready & ~hazard. Fire = ibuf_valid & ibuf_ready.
- Set: fire & ibuf_wb & rd≠0 → inuse[wid][rd] <= 1.
- Clear: wb_valid & wb_eop → inuse[wb_wid][wb_rd] <= 0. If that bit was already 0 (and wb_rd≠0), wb_error <= 1.
- Set and clear in the same cycle:
  - Different bits: both apply.
  - Same bit: set wins. This cannot occur legally, since the WAW check blocks it.
- wb_valid with wb_eop=0 does not change state.
- perf_stalls += 1 each cycle ibuf_valid & hazard. It wraps modulo 2^64.
- stall_cnt:
  - Increments while ibuf_valid & hazard; saturates at DEADLOCK_CYCLES.
  - Resets to 0 in any cycle without ibuf_valid & hazard.
  - deadlock <= 1 when stall_cnt reaches DEADLOCK_CYCLES-1 while still stalling.
- Stalls caused only by issue_ready=0 are not counted.

## Timing
- Issue path is combinational: valid/ready to valid/ready with zero latency. The demux registers its own outputs.
- Busy is visible one cycle after the issuing fire. An instruction issued in cycle N blocks dependents from cycle N+1.
- A clear in cycle N unblocks dependents from cycle N+1. There is a 1-cycle minimum gap between retire and dependent issue.
- Reset state: all inuse=0, stall_cnt=0, perf_stalls=0, deadlock=0, wb_error=0.
  - issue_valid follows ibuf_valid (no hazards after reset).
  - ibuf_ready follows issue_ready.
- Reset mid-operation drops all busy bits. Writebacks of pre-reset instructions that arrive after reset set wb_error; the environment must flush the pipeline together with this block.
- Handshake: issue_valid may drop without a fire only when hazard rises. Hazard can only rise via a set, which needs a fire, so a presented instruction that is not accepted stays presented.

## Test plan
- Reset, then warp 0 issues wb rd=5 (fire). Next cycle, rs1=5 use_rs=001 → issue_valid=0, ibuf_ready=0, perf_stalls increments per cycle. Apply wb_valid/eop wid0 rd5 → issue_valid=1 the following cycle.
- Warp 0 busy on rd=7; warp 1 issues rs1=7 → no hazard, issues immediately (per-warp isolation).
- WAW: rd=9 busy, new instruction wb rd=9 with use_rs=000 → stalled until the clear. Same-cycle issue of rd=10 and clear of rd=9 → both applied.
- rd=0 with wb=1 issued, then rs1=0 read → never stalls; inuse stays 0. wb_valid/eop on rd=0 → wb_error stays 0.
- Clear of non-busy rd=12 → wb_error=1 and holds. A multi-packet writeback (wb_eop=0 then 1) clears only on the eop packet.
- DEADLOCK_CYCLES=8: hold a hazard stall for 8 cycles → deadlock=1 and sticky. issue_ready=0 without a hazard for 20 cycles → deadlock=0, perf_stalls unchanged.
